// File: rtl/systolic_result_drain.sv
// -----------------------------------------------------------------------------
// systolic_result_drain
//
// Output-side companion of SystolicArray8x8. A start pulse marks the cycle on
// which skewed A/B injection begins. The drain counts SETTLE_CYCLES edges while
// the array settles. It then snapshots the whole C matrix into a local buffer
// and streams the buffer row-major, one element per beat, over a valid/ready
// port. The array may begin its next product once the snapshot has been taken.
//
// Build option:
//   DRAIN_CHECKSUM_EN - adds checksum / checksum_valid. The checksum is the
//                       wrapping sum of all transferred out_data words. It is
//                       presented together with done.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous reset, active-high
//   start          in   1-cycle pulse; accepted only while idle
//   c_in           in   [N][N] signed ACC_WIDTH results from the array
//   busy           out  high while waiting for settle or streaming
//   snap           out  1-cycle pulse after the snapshot edge
//   out_data       out  signed element C[out_row][out_col]
//   out_row        out  row index of the current beat
//   out_col        out  column index of the current beat
//   out_valid      out  beat valid
//   out_ready      in   sink accepts the beat
//   out_last       out  high with the C[N-1][N-1] beat
//   done           out  1-cycle pulse after the last beat transfers
//   checksum       out  (DRAIN_CHECKSUM_EN) sum of the streamed data
//   checksum_valid out  (DRAIN_CHECKSUM_EN) pulses with done
// -----------------------------------------------------------------------------
module systolic_result_drain #(
  parameter int N             = 8,
  parameter int ACC_WIDTH     = 32,
  parameter int SETTLE_CYCLES = 22
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [ACC_WIDTH-1:0] c_in [N][N],
  output logic                        busy,
  output logic                        snap,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic [$clog2(N)-1:0]        out_row,
  output logic [$clog2(N)-1:0]        out_col,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        done
`ifdef DRAIN_CHECKSUM_EN
  ,
  output logic signed [ACC_WIDTH-1:0] checksum,
  output logic                        checksum_valid
`endif
);

  localparam int TOTAL = N * N;
  localparam int RW    = $clog2(N);
  localparam int IW    = $clog2(TOTAL);
  // One extra bit so that SETTLE_CYCLES == 1 still gives a legal counter.
  localparam int CW    = $clog2(SETTLE_CYCLES + 1);

  localparam logic [IW-1:0] IDX_LAST   = IW'(TOTAL - 1);
  localparam logic [RW-1:0] COL_LAST   = RW'(N - 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_STREAM
  } state_t;

  state_t                       state;
  state_t                       state_d;
  logic [CW-1:0]                cnt;
  logic [IW-1:0]                idx;
  logic signed [ACC_WIDTH-1:0]  snap_buf [N][N];

  logic                         take_snap;
  logic                         xfer;
  logic                         finish;
  logic [RW-1:0]                row_nxt;
  logic [RW-1:0]                col_nxt;
  logic [IW-1:0]                idx_nxt;

  assign busy = (state != S_IDLE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked blocks use non-blocking (<=) so every register samples the
  // pre-edge value of the others; blocking here would create order-dependent
  // simulation that no longer matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and per-cycle strobes
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that left one
  // unassigned would make synthesis infer a latch to hold its old value.
  always_comb begin
    state_d   = state;
    take_snap = 1'b0;
    xfer      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          take_snap = 1'b1;
          state_d   = S_STREAM;
        end
      end
      S_STREAM: begin
        if (out_valid && out_ready) begin
          xfer = 1'b1;
          if (idx == IDX_LAST) begin
            finish  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Row/column of the beat that follows the current one. Walking row/col
  // directly avoids a divider when N is not a power of two.
  always_comb begin
    idx_nxt = idx + 1'b1;
    if (out_col == COL_LAST) begin
      col_nxt = '0;
      row_nxt = out_row + 1'b1;
    end else begin
      col_nxt = out_col + 1'b1;
      row_nxt = out_row;
    end
  end

  // ---------------------------------------------------------------------------
  // Settle counter, beat registers and strobes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      snap      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end else begin
      snap <= take_snap;
      done <= finish;

      if ((state == S_IDLE) && start) begin
        cnt <= CNT_RELOAD;
      end else if ((state == S_WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      if (take_snap) begin
        // The buffer is written on this same edge, so beat 0 comes straight
        // from the array.
        idx       <= '0;
        out_valid <= 1'b1;
        out_row   <= '0;
        out_col   <= '0;
        out_data  <= c_in[0][0];
        out_last  <= (TOTAL == 1);
      end else if (xfer) begin
        if (finish) begin
          idx       <= '0;
          out_valid <= 1'b0;
          out_row   <= '0;
          out_col   <= '0;
          out_data  <= '0;
          out_last  <= 1'b0;
        end else begin
          idx      <= idx_nxt;
          out_row  <= row_nxt;
          out_col  <= col_nxt;
          out_data <= snap_buf[row_nxt][col_nxt];
          out_last <= (idx_nxt == IDX_LAST);
        end
      end
      // Otherwise this is a stall or idle cycle: the beat registers hold.
    end
  end

  // ---------------------------------------------------------------------------
  // Snapshot buffer
  // ---------------------------------------------------------------------------
  // NOTE: the buffer has no reset. Its contents are only read after a snapshot
  // overwrites them, and leaving it unreset lets it map onto plain storage.
  always_ff @(posedge clk) begin
    if (take_snap) begin
      snap_buf <= c_in;
    end
  end

`ifdef DRAIN_CHECKSUM_EN
  // ---------------------------------------------------------------------------
  // Checksum of the transferred stream (wrapping two's-complement)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum       <= '0;
      checksum_valid <= 1'b0;
    end else begin
      checksum_valid <= finish;
      if (take_snap) begin
        checksum <= '0;
      end else if (xfer) begin
        checksum <= checksum + out_data;
      end
    end
  end
`else
  // No checksum accumulator in this build.
`endif

endmodule

// File: tb/tb_systolic_result_drain.sv
// -----------------------------------------------------------------------------
// tb_systolic_result_drain
//
// Directed bench for systolic_result_drain (N=8, ACC_WIDTH=32,
// SETTLE_CYCLES=22). The scenarios covered are:
//   - plain streaming
//   - matrix-product data
//   - backpressure with c_in changing after the snapshot
//   - ignored start pulses
//   - asynchronous reset during a stream
//   - all -1 data
// Expected beats come from a bench-side copy of the matrix that was driven.
// -----------------------------------------------------------------------------
module tb_systolic_result_drain;

  localparam int N      = 8;
  localparam int AW     = 32;
  localparam int SETTLE = 22;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic signed [AW-1:0] c_in [N][N];
  logic                 busy;
  logic                 snap;
  logic signed [AW-1:0] out_data;
  logic [2:0]           out_row;
  logic [2:0]           out_col;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 done;
`ifdef DRAIN_CHECKSUM_EN
  logic signed [AW-1:0] checksum;
  logic                 checksum_valid;
`endif

  int exp_c [N][N];
  int errors = 0;
  int checks = 0;

  systolic_result_drain #(
    .N             (N),
    .ACC_WIDTH     (AW),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .c_in           (c_in),
    .busy           (busy),
    .snap           (snap),
    .out_data       (out_data),
    .out_row        (out_row),
    .out_col        (out_col),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .done           (done)
`ifdef DRAIN_CHECKSUM_EN
    ,
    .checksum       (checksum),
    .checksum_valid (checksum_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive c_in and the expectation with the same matrix.
  task automatic load_ramp;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c_in[i][j]   = i * N + j;
        exp_c[i][j]  = i * N + j;
      end
  endtask

  task automatic load_product;
    int a [N][N];
    int b [N][N];
    int s;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a[i][j] = i * N + j + 1;
        b[i][j] = 64 - (i * N + j);
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += a[i][k] * b[k][j];
        c_in[i][j]  = s;
        exp_c[i][j] = s;
      end
  endtask

  task automatic load_minus_one;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c_in[i][j]  = -1;
        exp_c[i][j] = -1;
      end
  endtask

  // Pulse start (edge E0), then step to the snapshot edge E0+SETTLE.
  // extra_at > 0 re-pulses start so that edge E0+extra_at samples it.
  task automatic settle(input string tag, input int extra_at);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy@E0"}, busy, 1);
    check({tag, " valid@E0"}, out_valid, 0);
    for (int k = 1; k <= SETTLE; k++) begin
      if (k == extra_at) start = 1'b1;
      tick();
      start = 1'b0;
      if (k == SETTLE - 1) begin
        check({tag, " snap early"}, snap, 0);
        check({tag, " valid early"}, out_valid, 0);
      end
    end
    check({tag, " snap"}, snap, 1);
    check({tag, " busy snap"}, busy, 1);
    check({tag, " valid snap"}, out_valid, 1);
  endtask

  // Consume the stream beat by beat. A stall cycle re-checks the same beat,
  // which proves it held. abort_at >= 0 fires rst while that beat is presented.
  task automatic run_stream(input string tag, input int abort_at, input bit bp,
                            input bit start_at_done);
    int idx = 0;
    int cyc = 0;
    int sum = 0;
    bit fin = 1'b0;
    while (!fin) begin
      if (idx == abort_at) begin
        rst = 1'b1;
        #1;
        check({tag, " rst valid"}, out_valid, 0);
        check({tag, " rst busy"}, busy, 0);
        check({tag, " rst data"}, out_data, 0);
        check({tag, " rst last"}, out_last, 0);
        check({tag, " rst col"}, out_col, 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check({tag, " no done after abort"}, done, 0);
        check({tag, " idle after abort"}, busy, 0);
        return;
      end
      out_ready = bp ? (cyc % 3 == 0) : 1'b1;
      check($sformatf("%s b%0d valid", tag, idx), out_valid, 1);
      check($sformatf("%s b%0d data", tag, idx), out_data, exp_c[idx / N][idx % N]);
      check($sformatf("%s b%0d row", tag, idx), out_row, idx / N);
      check($sformatf("%s b%0d col", tag, idx), out_col, idx % N);
      check($sformatf("%s b%0d last", tag, idx), out_last, idx == N * N - 1);
      check($sformatf("%s b%0d done", tag, idx), done, 0);
      if (cyc > 0) check($sformatf("%s b%0d snap", tag, idx), snap, 0);
`ifdef DRAIN_CHECKSUM_EN
      check($sformatf("%s b%0d csv", tag, idx), checksum_valid, 0);
`endif
      if (start_at_done && out_ready && idx == N * N - 1) start = 1'b1;
      tick();
      start = 1'b0;
      if (out_ready) begin
        sum += exp_c[idx / N][idx % N];
        if (idx == N * N - 1) fin = 1'b1;
        idx++;
      end
      cyc++;
    end
    out_ready = 1'b1;
    check({tag, " done"}, done, 1);
    check({tag, " busy falls"}, busy, 0);
    check({tag, " valid falls"}, out_valid, 0);
    check({tag, " last falls"}, out_last, 0);
`ifdef DRAIN_CHECKSUM_EN
    check({tag, " csum valid"}, checksum_valid, 1);
    check({tag, " csum"}, checksum, sum);
`endif
    tick();
    check({tag, " done pulse"}, done, 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    load_ramp();
    repeat (3) tick();

    // Reset state
    check("rst busy", busy, 0);
    check("rst snap", snap, 0);
    check("rst valid", out_valid, 0);
    check("rst data", out_data, 0);
    check("rst row", out_row, 0);
    check("rst col", out_col, 0);
    check("rst last", out_last, 0);
    check("rst done", done, 0);
`ifdef DRAIN_CHECKSUM_EN
    check("rst csum", checksum, 0);
    check("rst csv", checksum_valid, 0);
`endif
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // 1: ramp data, sink always ready
    settle("s1", 0);
    run_stream("s1", -1, 1'b0, 1'b0);

    // 2: product data A*B, corner values computed by hand
    load_product();
    settle("s2", 0);
    check("s2 C00", out_data, 960);
    check("s2 C77 model", exp_c[N - 1][N - 1], 13700);
    run_stream("s2", -1, 1'b0, 1'b0);

    // 3: backpressure 1,0,0,... and c_in scrambled after the snapshot
    load_ramp();
    settle("s3", 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) c_in[i][j] = -1000 - (i * N + j);
    run_stream("s3", -1, 1'b1, 1'b0);

    // 4: extra start at E0+5 and in the done cycle, both ignored
    load_ramp();
    settle("s4", 5);
    run_stream("s4", -1, 1'b0, 1'b1);
    repeat (SETTLE + 4) tick();
    check("s4 no restart busy", busy, 0);
    check("s4 no restart valid", out_valid, 0);

    // 5: async reset at beat 20, then a fresh full stream
    settle("s5a", 0);
    run_stream("s5a", 20, 1'b0, 1'b0);
    settle("s5b", 0);
    run_stream("s5b", -1, 1'b0, 1'b0);

    // 6: all -1, sign preserved (checksum -64 when enabled)
    load_minus_one();
    settle("s6", 0);
    run_stream("s6", -1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
